// File: rtl/CPU_profile.sv
// Shared CPU-wide types and constants used by the unified-memory arbiter.
package CPU_profile;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned MEM_ARB_NUM_M = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-3:0] word_addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wstrb;
    } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// whichever requester did not win last time.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |valid;
        gnt = (valid == 2'b11) ? ~last_gnt : valid[1];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the IF (M0) and
// LSU (M1) requesters, one access outstanding, with out-of-range rejection.
module mem_port_arbiter
    import CPU_profile::*;
#(
    parameter int unsigned XLEN      = CPU_profile::XLEN,
    parameter int unsigned MEM_WORDS = 65536,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [MEM_ARB_NUM_M-1:0]            m_req_valid,
    output logic [MEM_ARB_NUM_M-1:0]            m_req_ready,
    input  logic [MEM_ARB_NUM_M-1:0]            m_req_we,
    input  logic [MEM_ARB_NUM_M-1:0][XLEN-1:0]  m_req_addr,
    input  logic [MEM_ARB_NUM_M-1:0][XLEN-1:0]  m_req_wdata,
    input  logic [MEM_ARB_NUM_M-1:0][3:0]       m_req_wstrb,
    output logic [MEM_ARB_NUM_M-1:0]            m_resp_valid,
    output logic [XLEN-1:0]                     m_resp_rdata,
    output logic                                m_resp_err,
    output logic                                mem_cs,
    output logic [3:0]                          mem_we,
    output logic [XLEN-3:0]                     mem_addr,
    output logic [XLEN-1:0]                     mem_wdata,
    input  logic [XLEN-1:0]                     mem_rdata
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be within 1..4");
    end
    if (XLEN != CPU_profile::XLEN) begin : g_bad_xlen
        $error("mem_port_arbiter: XLEN must match CPU_profile::XLEN");
    end

    arb_state_e      state, state_nxt;
    logic [1:0]      lat_cnt, lat_nxt;
    logic            last_gnt;
    logic            gnt;
    logic            any;
    logic            hs;
    logic [XLEN-1:0] sel_word;
    logic            req_err;
    mem_req_t        req_q;
    logic            gnt_q;
    logic            err_q;
    logic            cs_q;

    rr_pick2 u_pick (
        .valid    (m_req_valid),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .any      (any)
    );

    always_comb begin
        m_req_ready = '0;
        state_nxt   = state;
        lat_nxt     = lat_cnt;
        hs          = 1'b0;
        sel_word    = m_req_addr[gnt] >> 2;
        req_err     = (sel_word >= XLEN'(MEM_WORDS));
        unique case (state)
            IDLE: begin
                if (any) begin
                    m_req_ready[gnt] = 1'b1;
                    hs               = 1'b1;
                    if (!m_req_we[gnt] && !req_err) begin
                        state_nxt = WAIT;
                        lat_nxt   = 2'(RD_LAT - 1);
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == '0) state_nxt = RESP;
                else               lat_nxt   = lat_cnt - 2'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data lands during RESP; it is registered there together with the
    // response strobe, so the requester sees it the following cycle.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            last_gnt     <= 1'b1;
            req_q        <= '0;
            gnt_q        <= 1'b0;
            err_q        <= 1'b0;
            cs_q         <= 1'b0;
            m_resp_valid <= '0;
            m_resp_rdata <= '0;
            m_resp_err   <= 1'b0;
        end else begin
            state        <= state_nxt;
            lat_cnt      <= lat_nxt;
            cs_q         <= 1'b0;
            m_resp_valid <= '0;
            if (hs) begin
                req_q.we        <= m_req_we[gnt];
                req_q.word_addr <= sel_word[XLEN-3:0];
                req_q.wdata     <= m_req_wdata[gnt];
                req_q.wstrb     <= m_req_wstrb[gnt];
                gnt_q           <= gnt;
                err_q           <= req_err;
                cs_q            <= !req_err;
            end
            if (state == RESP) begin
                m_resp_valid[gnt_q] <= 1'b1;
                m_resp_rdata        <= (req_q.we || err_q) ? '0 : mem_rdata;
                m_resp_err          <= err_q;
                last_gnt            <= gnt_q;
            end
        end
    end

    always_comb begin
        mem_cs    = cs_q;
        mem_we    = (cs_q && req_q.we) ? req_q.wstrb : 4'b0000;
        mem_addr  = req_q.word_addr;
        mem_wdata = req_q.wdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3), each with
// a small RAM, checked every cycle against a transaction-level reference.
module tb_mem_port_arbiter;

    localparam int MW = 65536;
    localparam int RW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn   [2];
    logic [1:0]       valid  [2];
    logic [1:0]       ready  [2];
    logic [1:0]       we     [2];
    logic [1:0]       rvalid [2];
    logic [1:0][31:0] addr   [2];
    logic [1:0][31:0] wdata  [2];
    logic [1:0][3:0]  wstrb  [2];
    logic [31:0]      rdata  [2];
    logic             rerr   [2];
    logic             mcs    [2];
    logic [3:0]       mwe    [2];
    logic [29:0]      maddr  [2];
    logic [31:0]      mwdata [2];
    logic [31:0]      mrdata [2];

    bit [31:0] ram    [2][RW];
    bit [31:0] shadow [2][RW];
    bit        pv     [2][4];
    bit [31:0] pd     [2][4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          free_at [2];
    int          last    [2];
    int          due     [2];
    int          dport   [2];
    logic [31:0] ddata   [2];
    logic        derr    [2];
    int          cs_cyc  [2];
    logic [29:0] cs_addr [2];
    logic [3:0]  cs_we   [2];
    logic [31:0] cs_wd   [2];
    int          ghist   [2][64];
    int          gn      [2];

    mem_port_arbiter #(.XLEN(32), .MEM_WORDS(MW), .RD_LAT(1)) dut (
        .ACLK(clk), .ARESETn(rstn[0]),
        .m_req_valid(valid[0]), .m_req_ready(ready[0]), .m_req_we(we[0]),
        .m_req_addr(addr[0]), .m_req_wdata(wdata[0]), .m_req_wstrb(wstrb[0]),
        .m_resp_valid(rvalid[0]), .m_resp_rdata(rdata[0]), .m_resp_err(rerr[0]),
        .mem_cs(mcs[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0])
    );

    mem_port_arbiter #(.XLEN(32), .MEM_WORDS(MW), .RD_LAT(3)) dut3 (
        .ACLK(clk), .ARESETn(rstn[1]),
        .m_req_valid(valid[1]), .m_req_ready(ready[1]), .m_req_we(we[1]),
        .m_req_addr(addr[1]), .m_req_wdata(wdata[1]), .m_req_wstrb(wstrb[1]),
        .m_resp_valid(rvalid[1]), .m_resp_rdata(rdata[1]), .m_resp_err(rerr[1]),
        .mem_cs(mcs[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1])
    );

    // Synchronous RAM; read data appears on the bus only in its valid cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pv[k][0] <= mcs[k];
            pd[k][0] <= ram[k][maddr[k][7:0]];
            for (int s = 1; s < 4; s++) begin
                pv[k][s] <= pv[k][s-1];
                pd[k][s] <= pd[k][s-1];
            end
            if (mcs[k])
                for (int b = 0; b < 4; b++)
                    if (mwe[k][b]) ram[k][maddr[k][7:0]][8*b +: 8] <= mwdata[k][8*b +: 8];
        end
    end
    assign mrdata[0] = pv[0][0] ? pd[0][0] : 32'hBAD0_BAD0;
    assign mrdata[1] = pv[1][2] ? pd[1][2] : 32'hBAD0_BAD0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst%0d cyc%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_check(input int k);
        int          g;
        int          lat;
        logic [1:0]  er;
        logic [1:0]  ev;
        logic [31:0] w;
        logic        e;
        if (!rstn[k]) begin
            free_at[k] = 0; last[k] = 1; due[k] = -1; cs_cyc[k] = -1;
            return;
        end
        g = -1;
        if (cyc >= free_at[k]) begin
            if (valid[k] == 2'b11)  g = 1 - last[k];
            else if (valid[k][0])   g = 0;
            else if (valid[k][1])   g = 1;
        end
        er = (g < 0) ? 2'b00 : (2'b01 << g);
        chk("ready", k, 32'(ready[k]), 32'(er));
        ev = (cyc == due[k]) ? (2'b01 << dport[k]) : 2'b00;
        chk("resp_valid", k, 32'(rvalid[k]), 32'(ev));
        if (cyc == due[k]) begin
            chk("resp_rdata", k, rdata[k], ddata[k]);
            chk("resp_err", k, 32'(rerr[k]), 32'(derr[k]));
        end
        chk("mem_cs", k, 32'(mcs[k]), 32'(cyc == cs_cyc[k]));
        if (cyc == cs_cyc[k]) begin
            chk("mem_addr", k, 32'(maddr[k]), 32'(cs_addr[k]));
            chk("mem_we", k, 32'(mwe[k]), 32'(cs_we[k]));
            if (cs_we[k] != 4'b0000) chk("mem_wdata", k, mwdata[k], cs_wd[k]);
        end
        if (g >= 0) begin
            w   = addr[k][g] >> 2;
            e   = (w >= 32'(MW));
            lat = (!we[k][g] && !e) ? lat_of(k) + 2 : 2;
            due[k] = cyc + lat; free_at[k] = cyc + lat;
            dport[k] = g; derr[k] = e; last[k] = g;
            ddata[k] = (!we[k][g] && !e) ? shadow[k][w[7:0]] : 32'h0;
            if (!e) begin
                cs_cyc[k]  = cyc + 1;
                cs_addr[k] = w[29:0];
                cs_we[k]   = we[k][g] ? wstrb[k][g] : 4'b0000;
                cs_wd[k]   = wdata[k][g];
                if (we[k][g])
                    for (int b = 0; b < 4; b++)
                        if (wstrb[k][g][b]) shadow[k][w[7:0]][8*b +: 8] = wdata[k][g][8*b +: 8];
            end
            ghist[k][gn[k] % 64] = g;
            gn[k]++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_check(k);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int k, input int m, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        we[k][m] = w; addr[k][m] = a; wdata[k][m] = d; wstrb[k][m] = s;
    endtask

    task automatic preload(input int k, input int idx, input logic [31:0] v);
        ram[k][idx] <= v;
        shadow[k][idx] = v;
    endtask

    task automatic chk_idle_outputs(input int k, input string tag);
        chk({tag, "_ready"}, k, 32'(ready[k]), 32'h0);
        chk({tag, "_rvalid"}, k, 32'(rvalid[k]), 32'h0);
        chk({tag, "_rdata"}, k, rdata[k], 32'h0);
        chk({tag, "_rerr"}, k, 32'(rerr[k]), 32'h0);
        chk({tag, "_mcs"}, k, 32'(mcs[k]), 32'h0);
        chk({tag, "_mwe"}, k, 32'(mwe[k]), 32'h0);
        chk({tag, "_maddr"}, k, 32'(maddr[k]), 32'h0);
        chk({tag, "_mwdata"}, k, mwdata[k], 32'h0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstn[k] = 1'b0; valid[k] = 2'b00;
            set_req(k, 0, 1'b0, 32'h0, 32'h0, 4'h0);
            set_req(k, 1, 1'b0, 32'h0, 32'h0, 4'h0);
            free_at[k] = 0; last[k] = 1; due[k] = -1; cs_cyc[k] = -1; gn[k] = 0;
        end
        preload(0, 4, 32'hDEAD_BEEF);
        preload(0, 0, 32'hCAFE_0001);
        preload(0, 8'h80, 32'h1111_2222);
        preload(1, 7, 32'h0BAD_F00D);
        preload(1, 9, 32'h5555_AAAA);
        @(posedge clk); #1;
        repeat (2) cycle();
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        chk_idle_outputs(0, "reset");
        chk_idle_outputs(1, "reset");

        // M0 read of a preloaded word
        valid[0] = 2'b01; set_req(0, 0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        cycle();
        valid[0] = 2'b00;
        repeat (5) cycle();

        // Both requesters continuously valid from reset
        rstn[0] = 1'b0; cycle(); rstn[0] = 1'b1;
        gn[0] = 0;
        valid[0] = 2'b11;
        set_req(0, 0, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
        set_req(0, 1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF);
        repeat (12) cycle();
        valid[0] = 2'b00;
        repeat (6) cycle();
        chk("rr_first_grants", 0, 32'(gn[0] >= 4), 32'h1);
        chk("rr_grant0", 0, 32'(ghist[0][0]), 32'd0);
        chk("rr_grant1", 0, 32'(ghist[0][1]), 32'd1);
        chk("rr_grant2", 0, 32'(ghist[0][2]), 32'd0);
        chk("rr_grant3", 0, 32'(ghist[0][3]), 32'd1);
        for (int i = 0; i + 1 < gn[0] && i + 1 < 64; i++)
            chk("rr_alternate", 0, 32'(ghist[0][i+1]), 32'(1 - ghist[0][i]));
        chk("rr_write_mem", 0, ram[0][8'h40], 32'h1234_5678);

        // Partial-byte write
        valid[0] = 2'b10; set_req(0, 1, 1'b1, 32'h0000_0200, 32'hAAAA_BBBB, 4'b0011);
        cycle();
        valid[0] = 2'b00;
        repeat (4) cycle();
        chk("strb_merge", 0, ram[0][8'h80], 32'h1111_BBBB);

        // Out-of-range read
        valid[0] = 2'b01; set_req(0, 0, 1'b0, 32'h0004_0000, 32'h0, 4'h0);
        cycle();
        valid[0] = 2'b00;
        repeat (4) cycle();

        // RD_LAT=3 read with the other requester held valid throughout WAIT
        valid[1] = 2'b10; set_req(1, 1, 1'b0, 32'h0000_001C, 32'h0, 4'h0);
        set_req(1, 0, 1'b0, 32'h0000_0024, 32'h0, 4'h0);
        cycle();
        valid[1] = 2'b11;
        repeat (6) cycle();
        valid[1] = 2'b00;
        repeat (8) cycle();

        // Reset during WAIT discards the in-flight read
        valid[1] = 2'b01; set_req(1, 0, 1'b0, 32'h0000_0024, 32'h0, 4'h0);
        cycle();
        valid[1] = 2'b00;
        rstn[1] = 1'b0;
        cycle();
        rstn[1] = 1'b1;
        chk_idle_outputs(1, "rst_wait");
        repeat (6) cycle();
        valid[1] = 2'b11;
        set_req(1, 1, 1'b0, 32'h0000_001C, 32'h0, 4'h0);
        #1;
        chk("rst_first_gnt", 1, 32'(ready[1]), 32'h1);
        cycle();
        valid[1] = 2'b00;
        repeat (7) cycle();

        // Randomised traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                valid[k] = 2'($urandom_range(0, 3));
                for (int m = 0; m < 2; m++) begin
                    if ($urandom_range(0, 7) == 0)
                        set_req(k, m, 1'($urandom), 32'h0004_0000 + ($urandom & 32'h0FFF_FFFF),
                                $urandom, 4'($urandom));
                    else
                        set_req(k, m, 1'($urandom), {22'h0, 8'($urandom_range(0, RW - 1)), 2'($urandom)},
                                $urandom, 4'($urandom));
                end
            end
            cycle();
        end
        valid[0] = 2'b00; valid[1] = 2'b00;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
